// File: rtl/quantum_timer_if.sv
// Control-decoder <-> quantum timer bundle: decoder commands in, interrupt/count status out.
interface quantum_timer_if #(
  parameter int WIDTH = 16,
  parameter int PCW   = 32
);
  logic             stopQnt;
  logic             rstQnt;
  logic             Halt;
  logic [PCW-1:0]   pcIn;
  logic             intSig;
  logic [PCW-1:0]   savedPC;
  logic [WIDTH-1:0] count;
  logic             running;

  modport master (
    output stopQnt, rstQnt, Halt, pcIn,
    input  intSig, savedPC, count, running
  );

  modport slave (
    input  stopQnt, rstQnt, Halt, pcIn,
    output intSig, savedPC, count, running
  );
endinterface

// File: rtl/quantum_timer.sv
// Time-slice timer: counts QUANTUM cycles per slice, raises an interrupt and
// captures the program counter at slice end, waits for the decoder to acknowledge.
//
// state | meaning
// IDLE  | after reset, waiting for the first slice restart
// RUN   | counting the current slice (paused while halted)
// PEND  | slice expired, interrupt raised, waiting for acknowledge
// STOP  | slice frozen, waiting for a restart
module quantum_timer #(
  parameter int QUANTUM = 100,
  parameter int WIDTH   = 16,
  parameter int PCW     = 32
) (
  input logic            clk,
  input logic            rst,
  quantum_timer_if.slave qt
);

  typedef enum logic [1:0] {IDLE, RUN, PEND, STOP} state_t;

  localparam logic [WIDTH-1:0] LAST = WIDTH'(QUANTUM - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_q, count_nxt;
  logic             int_q, int_nxt;
  logic [PCW-1:0]   pc_q, pc_nxt;
  logic             run_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count_q <= '0;
      int_q   <= 1'b0;
      pc_q    <= '0;
      run_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      count_q <= count_nxt;
      int_q   <= int_nxt;
      pc_q    <= pc_nxt;
      run_q   <= (state_nxt == RUN);
    end
  end

  // Priority everywhere: rstQnt, then stopQnt, then Halt, then counting.
  always_comb begin
    state_nxt = state;
    count_nxt = count_q;
    int_nxt   = int_q;
    pc_nxt    = pc_q;
    case (state)
      IDLE: begin
        int_nxt = 1'b0;
        if (qt.rstQnt) begin
          state_nxt = RUN;
          count_nxt = '0;
        end
      end
      RUN: begin
        int_nxt = 1'b0;
        if (qt.rstQnt) begin
          count_nxt = '0;
        end else if (qt.stopQnt) begin
          state_nxt = STOP;
        end else if (!qt.Halt) begin
          if (count_q >= LAST) begin
            state_nxt = PEND;
            count_nxt = '0;
            int_nxt   = 1'b1;
            pc_nxt    = qt.pcIn;
          end else begin
            count_nxt = count_q + 1'b1;
          end
        end
      end
      PEND: begin
        count_nxt = '0;
        int_nxt   = 1'b1;
        if (qt.rstQnt) begin
          state_nxt = RUN;
          int_nxt   = 1'b0;
        end else if (qt.stopQnt) begin
          state_nxt = STOP;
          int_nxt   = 1'b0;
        end
      end
      STOP: begin
        int_nxt = 1'b0;
        if (qt.rstQnt) begin
          state_nxt = RUN;
          count_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
        int_nxt   = 1'b0;
      end
    endcase
  end

  assign qt.intSig  = int_q;
  assign qt.savedPC = pc_q;
  assign qt.count   = count_q;
  assign qt.running = run_q;

endmodule

// File: tb/tb_quantum_timer.sv
// Directed bench for quantum_timer with QUANTUM=4; expected values hand-derived.
module tb_quantum_timer;
  localparam int QUANTUM = 4;
  localparam int WIDTH   = 16;
  localparam int PCW     = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  quantum_timer_if #(.WIDTH(WIDTH), .PCW(PCW)) qt ();

  quantum_timer #(.QUANTUM(QUANTUM), .WIDTH(WIDTH), .PCW(PCW)) dut (
    .clk (clk),
    .rst (rst),
    .qt  (qt.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] cnt, input logic intr,
                           input logic run, input logic [31:0] pc);
    check({tag, ".count"},   32'(qt.count), cnt);
    check({tag, ".intSig"},  32'(qt.intSig), 32'(intr));
    check({tag, ".running"}, 32'(qt.running), 32'(run));
    check({tag, ".savedPC"}, qt.savedPC, pc);
  endtask

  initial begin
    qt.stopQnt = 1'b0;
    qt.rstQnt  = 1'b0;
    qt.Halt    = 1'b0;
    qt.pcIn    = 32'h0;

    // Reset, then idle with noise on ignored inputs
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all("reset", 0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      qt.Halt    = i[0];
      qt.stopQnt = i[1];
      qt.pcIn    = 32'(i * 16);
      step();
      check_all("idle", 0, 1'b0, 1'b0, 32'h0);
    end
    qt.Halt    = 1'b0;
    qt.stopQnt = 1'b0;

    // Full slice with constant pc
    qt.pcIn   = 32'h40;
    qt.rstQnt = 1'b1;
    step();
    qt.rstQnt = 1'b0;
    check_all("slice.c0", 0, 1'b0, 1'b1, 32'h0);
    step(); check_all("slice.c1", 1, 1'b0, 1'b1, 32'h0);
    step(); check_all("slice.c2", 2, 1'b0, 1'b1, 32'h0);
    step(); check_all("slice.c3", 3, 1'b0, 1'b1, 32'h0);
    step(); check_all("slice.pend", 0, 1'b1, 1'b0, 32'h40);
    qt.Halt = 1'b1;
    step(); check_all("slice.pend_hold1", 0, 1'b1, 1'b0, 32'h40);
    qt.Halt = 1'b0;
    step(); check_all("slice.pend_hold2", 0, 1'b1, 1'b0, 32'h40);
    qt.stopQnt = 1'b1;
    step();
    qt.stopQnt = 1'b0;
    check_all("slice.ack", 0, 1'b0, 1'b0, 32'h40);
    qt.stopQnt = 1'b1;
    step();
    qt.stopQnt = 1'b0;
    check_all("slice.stop_ignores_stop", 0, 1'b0, 1'b0, 32'h40);

    // Halt pauses counting
    qt.rstQnt = 1'b1;
    step();
    qt.rstQnt = 1'b0;
    check_all("halt.c0", 0, 1'b0, 1'b1, 32'h40);
    step(); check_all("halt.c1", 1, 1'b0, 1'b1, 32'h40);
    step(); check_all("halt.c2", 2, 1'b0, 1'b1, 32'h40);
    qt.Halt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_all("halt.held", 2, 1'b0, 1'b1, 32'h40);
    end
    qt.Halt = 1'b0;
    qt.pcIn = 32'h80;
    step(); check_all("halt.c3", 3, 1'b0, 1'b1, 32'h40);
    step(); check_all("halt.pend", 0, 1'b1, 1'b0, 32'h80);

    // rstQnt from PEND
    qt.rstQnt = 1'b1;
    step();
    qt.rstQnt = 1'b0;
    check_all("pend_restart", 0, 1'b0, 1'b1, 32'h80);

    // stopQnt and rstQnt together at terminal count
    step(); step(); step();
    check_all("both.pre", 3, 1'b0, 1'b1, 32'h80);
    qt.stopQnt = 1'b1;
    qt.rstQnt  = 1'b1;
    step();
    qt.stopQnt = 1'b0;
    qt.rstQnt  = 1'b0;
    check_all("both.post", 0, 1'b0, 1'b1, 32'h80);

    // stopQnt alone at terminal count
    qt.pcIn = 32'h99;
    step(); step(); step();
    check_all("stop.pre", 3, 1'b0, 1'b1, 32'h80);
    qt.stopQnt = 1'b1;
    step();
    qt.stopQnt = 1'b0;
    check_all("stop.post", 3, 1'b0, 1'b0, 32'h80);
    qt.Halt = 1'b1;
    step(); check_all("stop.hold1", 3, 1'b0, 1'b0, 32'h80);
    qt.Halt = 1'b0;
    step(); check_all("stop.hold2", 3, 1'b0, 1'b0, 32'h80);
    qt.rstQnt = 1'b1;
    step();
    qt.rstQnt = 1'b0;
    check_all("stop.restart", 0, 1'b0, 1'b1, 32'h80);

    // Halt exactly at terminal count defers the interrupt
    step(); step(); step();
    check_all("haltterm.pre", 3, 1'b0, 1'b1, 32'h80);
    qt.Halt = 1'b1;
    qt.pcIn = 32'hC0;
    step(); check_all("haltterm.held", 3, 1'b0, 1'b1, 32'h80);
    qt.Halt = 1'b0;
    step(); check_all("haltterm.pend", 0, 1'b1, 1'b0, 32'hC0);

    // Reset in PEND overrides rstQnt and loses the interrupt
    rst       = 1'b1;
    qt.rstQnt = 1'b1;
    step();
    rst       = 1'b0;
    qt.rstQnt = 1'b0;
    check_all("pend_rst", 0, 1'b0, 1'b0, 32'h0);
    step(); check_all("pend_rst.idle", 0, 1'b0, 1'b0, 32'h0);
    qt.rstQnt = 1'b1;
    step();
    qt.rstQnt = 1'b0;
    check_all("idle_restart", 0, 1'b0, 1'b1, 32'h0);
    step(); check_all("idle_restart.c1", 1, 1'b0, 1'b1, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/quantum_timer.md
QUANTUM_TIMER -- requirements
Module: quantum_timer

Interface
REQ-001 Parameter QUANTUM, 100: cycles of counting per time slice (>=2).
REQ-002 Parameter WIDTH, 16: counter width; QUANTUM SHALL be <= 2^WIDTH-1.
REQ-003 Parameter PCW, 32: program-counter width.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 stopQnt  input  1  from control decoder: stop/acknowledge, freezes counter.
REQ-007 rstQnt  input  1  from control decoder: restart slice from zero.
REQ-008 Halt  input  1  from control decoder: processor halted, counting paused.
REQ-009 pcIn  input  PCW  current program counter.
REQ-010 intSig  output  1  interrupt request to control decoder, registered.
REQ-011 savedPC  output  PCW  pcIn captured when interrupt raised.
REQ-012 count  output  WIDTH  current slice count, registered.
REQ-013 running  output  1  high only in state RUN.

Function
REQ-014 States SHALL be IDLE, RUN, PEND, STOP; encoding free.
REQ-015 IDLE: count held, intSig=0; rstQnt -> RUN with count=0; all other inputs ignored.
REQ-016 RUN, Halt=0, no stop/rst: count increments by 1 per cycle.
REQ-017 RUN, Halt=1: count held; state unchanged.
REQ-018 RUN, count==QUANTUM-1, Halt=0, no stop/rst: next cycle PEND, intSig=1, count=0, savedPC=pcIn sampled that cycle.
REQ-019 RUN, stopQnt=1 (rstQnt=0): next cycle STOP, count held.
REQ-020 PEND: intSig held 1 until stopQnt=1 sampled; then next cycle STOP, intSig=0.
REQ-021 PEND: count held at 0, savedPC held; Halt ignored.
REQ-022 STOP: count and savedPC held, intSig=0; stopQnt ignored; only rstQnt leaves (-> RUN, count=0).
REQ-023 rstQnt=1 in RUN, PEND or STOP: next cycle RUN, count=0, intSig=0; savedPC unchanged.
REQ-024 stopQnt and rstQnt both 1 in same cycle: rstQnt SHALL win.
REQ-025 Terminal-count and stopQnt in same RUN cycle: stopQnt wins; no interrupt, savedPC unchanged.
REQ-026 Terminal-count and Halt=1 in same cycle: no interrupt; raised on first cycle with Halt=0.
REQ-027 count SHALL never exceed QUANTUM-1; no wrap-around path.
REQ-028 All outputs SHALL be registers; no combinational input-to-output path.

Reset
REQ-029 rst=1 SHALL force next cycle: state IDLE, count=0, intSig=0, savedPC=0, running=0.
REQ-030 rst SHALL override stopQnt, rstQnt and Halt in the same cycle.
REQ-031 rst asserted in PEND SHALL drop intSig next cycle; pending interrupt SHALL be lost.

Verification (QUANTUM=4)
REQ-032 rst 1 cycle, then idle 10 cycles -> intSig=0, count=0, running=0 throughout.
REQ-033 rstQnt pulse, pcIn=0x40 constant -> count 0,1,2,3; next cycle intSig=1, savedPC=0x40, count=0; intSig stays 1 until stopQnt pulse, then 0 and running=0.
REQ-034 rstQnt, 2 counting cycles, Halt=1 for 5 cycles, Halt=0 -> count holds at 2 during Halt, intSig rises exactly 2 counting cycles after Halt drops.
REQ-035 In RUN at count=3, stopQnt=1 and rstQnt=1 together -> next cycle RUN, count=0, intSig=0.
REQ-036 In RUN at count=3, stopQnt=1 alone -> STOP, count=3 held, intSig never asserted; later rstQnt -> RUN, count=0.
REQ-037 In PEND, rst=1 -> next cycle IDLE, intSig=0, savedPC=0.
